// File: rtl/conv_accumulator.sv
// Multiply-accumulate stage behind the convolution address/weight generator.
// Sums TAPS weighted pixel rows, normalises and saturates each window, then queues the result with its output index.
module conv_accumulator #(
    parameter int TAPS       = 3,
    parameter int SHIFT      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_first,
    input  logic              in_last,
    input  logic [23:0]       pixels,
    input  logic [23:0]       weight,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [7:0]        out_pixel,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              overflow,
    output logic              tap_err
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(TAPS + 1) + 1;

    function automatic logic [15:0] mul8(input logic [7:0] a, input logic [7:0] b);
        return {8'd0, a} * {8'd0, b};
    endfunction

    function automatic logic [7:0] sat8(input logic [19:0] v);
        return (v > 20'd255) ? 8'hFF : v[7:0];
    endfunction

    // Stage p0: input capture
    logic        vld_p0, first_p0, last_p0;
    logic [23:0] pixels_p0, weight_p0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p0   <= 1'b0;
            first_p0 <= 1'b0;
            last_p0  <= 1'b0;
        end else begin
            vld_p0   <= in_valid;
            first_p0 <= in_valid & in_first;
            last_p0  <= in_valid & in_last;
        end
    end

    always_ff @(posedge clk) begin
        pixels_p0 <= pixels;
        weight_p0 <= weight;
    end

    // Stage p1: row dot product
    logic        vld_p1, first_p1, last_p1;
    logic [17:0] row_sum_p1;
    logic [17:0] row_sum_c;

    always_comb begin
        row_sum_c = {2'd0, mul8(pixels_p0[23:16], weight_p0[23:16])}
                  + {2'd0, mul8(pixels_p0[15:8],  weight_p0[15:8])}
                  + {2'd0, mul8(pixels_p0[7:0],   weight_p0[7:0])};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1   <= 1'b0;
            first_p1 <= 1'b0;
            last_p1  <= 1'b0;
        end else begin
            vld_p1   <= vld_p0;
            first_p1 <= first_p0;
            last_p1  <= last_p0;
        end
    end

    always_ff @(posedge clk) begin
        row_sum_p1 <= row_sum_c;
    end

    // Stage p2: accumulate, close window, push result
    logic [19:0]      acc, acc_next;
    logic [CNT_W-1:0] tap_cnt, cnt_next;
    logic             win_open;
    logic [7:0]       result;

    always_comb begin
        acc_next = first_p1 ? {2'd0, row_sum_p1} : acc + {2'd0, row_sum_p1};
        // Saturating count so an overlong window cannot wrap back to TAPS.
        if (first_p1)
            cnt_next = CNT_W'(1);
        else if (tap_cnt == {CNT_W{1'b1}})
            cnt_next = tap_cnt;
        else
            cnt_next = tap_cnt + CNT_W'(1);
        result = sat8(acc_next >> SHIFT);
    end

    logic [7:0]        fifo_pix  [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr, rd_ptr;
    logic [ADDR_W-1:0] wr_index;
    logic              empty, full, push_req, pop, push;

    always_comb begin
        empty    = (wr_ptr == rd_ptr);
        full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
        push_req = vld_p1 & last_p1;
        pop      = ~empty & out_ready;
        push     = push_req & (~full | pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc      <= '0;
            tap_cnt  <= '0;
            win_open <= 1'b0;
            tap_err  <= 1'b0;
            overflow <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            wr_index <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pix[i]  <= '0;
                fifo_addr[i] <= '0;
            end
        end else begin
            if (vld_p1) begin
                acc      <= last_p1 ? '0 : acc_next;
                tap_cnt  <= last_p1 ? '0 : cnt_next;
                win_open <= ~last_p1;
                if (last_p1 && cnt_next != CNT_W'(TAPS))
                    tap_err <= 1'b1;
            end
            if (push) begin
                fifo_pix[wr_ptr[PTR_W-1:0]]  <= result;
                fifo_addr[wr_ptr[PTR_W-1:0]] <= wr_index;
                wr_ptr   <= wr_ptr + 1'b1;
                wr_index <= wr_index + 1'b1;
            end else if (push_req) begin
                overflow <= 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign out_valid = ~empty;
    assign out_pixel = fifo_pix[rd_ptr[PTR_W-1:0]];
    assign out_addr  = fifo_addr[rd_ptr[PTR_W-1:0]];
    assign busy      = vld_p0 | vld_p1 | win_open;

endmodule
